// File: rtl/inst_queue.sv
`timescale 1ns/1ps
// inst_queue: circular instruction/PC queue between fetch (IF) and decode (ID).
// The head entry is shown ahead combinationally. ID pops it with a one-cycle
// enable. A flush empties the queue on a redirect.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset (takes effect regardless of rdy)
//   rdy                global ready; when low, push/pop/flush are ignored and state holds
//   IF_inst_valid      push request carrying IF_inst / IF_pc
//   flush              discard all entries (head/tail/count cleared, memory untouched)
//   ID_enable          pop request for the current head entry
//   inst, pc           head entry, forced to 0 while empty
//   queue_is_empty     count == 0
//   queue_is_full      count == DEPTH
//   queue_almost_full  free slots <= AF_MARGIN
//
// DEPTH must equal 2**ADDR_WIDTH so pointers wrap naturally.
module inst_queue #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_inst_valid,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_pc,
    output logic        queue_is_full,
    output logic        queue_almost_full,
    input  logic        flush,
    input  logic        ID_enable,
    output logic        queue_is_empty,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_CNT    = CNT_WIDTH'(AF_MARGIN);

    logic [DATA_WIDTH-1:0] mem_inst [DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc   [DEPTH];

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [CNT_WIDTH-1:0]  free_slots;

    logic push_ok;
    logic pop_ok;
    logic advance;

    // Both qualifiers use the occupancy before this cycle's update, so a push
    // while full is dropped even if a pop happens in the same cycle.
    assign push_ok = IF_inst_valid && (count < DEPTH_CNT);
    assign pop_ok  = ID_enable && (count != '0);

    // Normal push/pop activity: rdy high, no reset or flush in this cycle.
    assign advance = rdy && !rst && !flush;

    // Occupancy update; a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CNT_WIDTH'(1);
            2'b01:   count_next = count - CNT_WIDTH'(1);
            default: count_next = count;
        endcase
    end

    // Pointer and count registers: reset beats rdy; flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push_ok) begin
                    tail <= tail + ADDR_WIDTH'(1);
                end
                if (pop_ok) begin
                    head <= head + ADDR_WIDTH'(1);
                end
                count <= count_next;
            end
        end
    end

    // Storage is deliberately not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (advance && push_ok) begin
            mem_inst[tail] <= IF_inst;
            mem_pc[tail]   <= IF_pc;
        end
    end

    // Status flags, derived from the registered count.
    assign free_slots        = DEPTH_CNT - count;
    assign queue_is_empty    = (count == '0);
    assign queue_is_full     = (count == DEPTH_CNT);
    assign queue_almost_full = (free_slots <= AF_CNT);

    // Show-ahead head entry, zeroed when nothing is queued.
    assign inst = queue_is_empty ? '0 : mem_inst[head];
    assign pc   = queue_is_empty ? '0 : mem_pc[head];

endmodule

// File: tb/tb_inst_queue.sv
`timescale 1ns/1ps
// tb_inst_queue: drives directed and random traffic into inst_queue. A
// queue-based reference model predicts the visible state after every edge.
// A separate monitor compares that prediction with the DUT on the falling edge.
module tb_inst_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFM   = 2;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IF_inst_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic        queue_is_full;
    logic        queue_almost_full;
    logic        flush;
    logic        ID_enable;
    logic        queue_is_empty;
    logic [31:0] inst;
    logic [31:0] pc;

    inst_queue #(.DEPTH(16), .ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .IF_inst_valid    (IF_inst_valid),
        .IF_inst          (IF_inst),
        .IF_pc            (IF_pc),
        .queue_is_full    (queue_is_full),
        .queue_almost_full(queue_almost_full),
        .flush            (flush),
        .ID_enable        (ID_enable),
        .queue_is_empty   (queue_is_empty),
        .inst             (inst),
        .pc               (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        empty;
        logic        full;
        logic        afull;
        logic [31:0] inst;
        logic [31:0] pc;
    } snap_t;

    logic [63:0] model_q [$];
    snap_t       exp_q   [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of {inst, pc}.
    task automatic model_update();
        logic do_push;
        logic do_pop;
        snap_t s;
        int n;
        if (rst) begin
            model_q.delete();
        end else if (rdy) begin
            if (flush) begin
                model_q.delete();
            end else begin
                n = model_q.size();
                do_push = IF_inst_valid && (n < DEPTH);
                do_pop  = ID_enable && (n > 0);
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back({IF_inst, IF_pc});
            end
        end
        n = model_q.size();
        s.empty = (n == 0);
        s.full  = (n == DEPTH);
        s.afull = ((DEPTH - n) <= AFM);
        s.inst  = (n == 0) ? 32'h0 : model_q[0][63:32];
        s.pc    = (n == 0) ? 32'h0 : model_q[0][31:0];
        exp_q.push_back(s);
    endtask

    // One clock: inputs are already stable; the model follows the edge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic rd, input logic v, input logic [31:0] i,
                         input logic [31:0] p, input logic fl, input logic en);
        rst = r; rdy = rd; IF_inst_valid = v; IF_inst = i; IF_pc = p; flush = fl; ID_enable = en;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 1, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        drive(0, 1, 1, i, p, 0, 0);
    endtask

    task automatic pop();
        drive(0, 1, 0, 32'h0, 32'h0, 0, 1);
    endtask

    task automatic pushpop(input logic [31:0] i, input logic [31:0] p);
        drive(0, 1, 1, i, p, 0, 1);
    endtask

    // Monitor: checks every prediction against the DUT away from the edge.
    always @(negedge clk) begin
        snap_t s;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("empty", 32'(queue_is_empty),    32'(s.empty));
            check("full",  32'(queue_is_full),     32'(s.full));
            check("afull", 32'(queue_almost_full), 32'(s.afull));
            check("inst",  inst, s.inst);
            check("pc",    pc,   s.pc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; IF_inst_valid = 1'b0; IF_inst = '0; IF_pc = '0;
        flush = 1'b0; ID_enable = 1'b0;
        #1;

        // Reset, then idle with stray pops.
        drive(1, 1, 0, 32'h0, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) pop();

        // Fill to full, plus one push that is dropped, then drain in order.
        for (int i = 0; i < 17; i++) push(32'h13 + 32'(i), 32'(4 * i));
        for (int i = 0; i < 17; i++) pop();

        // Wrap-around of both pointers.
        for (int i = 0; i < 10; i++) push(32'hA000_0000 + 32'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 12; i++) push(32'hB000_0000 + 32'(i), 32'h200 + 32'(i));
        for (int i = 0; i < 12; i++) pop();

        // Simultaneous push and pop at count 5, at empty, and at full.
        for (int i = 0; i < 5; i++) push(32'hC000_0000 + 32'(i), 32'h300 + 32'(i));
        for (int i = 0; i < 20; i++) pushpop(32'hC100_0000 + 32'(i), 32'h400 + 32'(i));
        for (int i = 0; i < 5; i++) pop();
        pushpop(32'hD000_0000, 32'h500);
        for (int i = 1; i < 16; i++) push(32'hD000_0000 + 32'(i), 32'h500 + 32'(i));
        pushpop(32'hDEAD_BEEF, 32'hDEAD);
        for (int i = 0; i < 16; i++) pop();

        // Flush with push and pop asserted at count 7, then push a new head.
        for (int i = 0; i < 7; i++) push(32'hE000_0000 + 32'(i), 32'h600 + 32'(i));
        drive(0, 1, 1, 32'hEEEE_EEEE, 32'hEEEE, 1, 1);
        push(32'h0000_0093, 32'h1000);
        idle(1);
        pop();

        // rdy stall with everything asserted, then reset while stalled.
        for (int i = 0; i < 3; i++) push(32'hF000_0000 + 32'(i), 32'h700 + 32'(i));
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 32'hF0F0_F0F0, 32'hF0F0, 1, 1);
        drive(1, 0, 0, 32'h0, 32'h0, 0, 0);
        idle(1);

        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) < 6),
                  $urandom(), $urandom(),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1));
        end
        idle(2);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
